// File: rtl/ingress_frame_filter_if.sv
// ingress_frame_filter_if: stream bundle (data, valid, last, error flag, ready) used for ingress and egress
interface ingress_frame_filter_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic tvalid;
    logic tlast;
    logic tuser;
    logic tready;
    modport master(output tdata, tvalid, tlast, tuser, input tready);
    modport slave(input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/ingress_frame_filter.sv
// ingress_frame_filter: store-and-forward frame buffer that drops bad, oversize or unbufferable frames
module ingress_frame_filter #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 11,
    parameter int SB_ADDR_WIDTH   = 9,
    parameter int MAX_FRAME_WORDS = 759,
    parameter int DROP_ON_ERROR   = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    ingress_frame_filter_if.slave  s,
    ingress_frame_filter_if.master m,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count
);
    localparam int LW = $clog2(MAX_FRAME_WORDS + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] DROP = 2'd2;
    localparam logic [0:0] OIDLE = 1'b0;
    localparam logic [0:0] OSTREAM = 1'b1;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [LW-1:0] sb_mem [2**SB_ADDR_WIDTH];
    logic [1:0] state;
    logic [0:0] ostate;
    logic [ADDR_WIDTH:0] wptr, cptr, rptr;
    logic [SB_ADDR_WIDTH:0] sb_wptr, sb_rptr;
    logic [LW-1:0] wcnt, rem, eff;
    logic beat, full, sb_full, sb_empty, admit, overflow, err, keep, commit, drop;
    logic pop, have, room, issue, rd_v, rd_last, sk_valid, sk_last;
    logic [DATA_WIDTH-1:0] rd_data, sk_data;

    assign s.tready = !reset;
    assign m.tuser = 1'b0;

    always_comb begin
        beat = s.tvalid && s.tready;
        full = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) && (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
        sb_full = (sb_wptr[SB_ADDR_WIDTH] != sb_rptr[SB_ADDR_WIDTH]) && (sb_wptr[SB_ADDR_WIDTH-1:0] == sb_rptr[SB_ADDR_WIDTH-1:0]);
        sb_empty = sb_wptr == sb_rptr;
        // en only matters on the first beat; RECV frames are already admitted
        admit = (state == IDLE) ? (en && !full && !sb_full) : (state == RECV);
        overflow = !s.tlast && (int'(wcnt) + 1 >= MAX_FRAME_WORDS);
        err = s.tlast && s.tuser && (DROP_ON_ERROR != 0);
        keep = beat && admit && !full && !overflow && !s.tlast;
        commit = beat && admit && !full && s.tlast && !err;
        drop = beat && (admit ? (full || overflow || err) : (state == IDLE && en));
        pop = m.tvalid && m.tready;
        have = (ostate == OSTREAM) || !sb_empty;
        eff = (ostate == OSTREAM) ? rem : sb_mem[sb_rptr[SB_ADDR_WIDTH-1:0]];
        // output register + skid + in-flight read never exceed two words after this edge
        room = (2'(m.tvalid) + 2'(sk_valid) + 2'(rd_v) - 2'(pop)) <= 2'd1;
        issue = have && room;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            wptr <= '0;
            cptr <= '0;
            wcnt <= '0;
            sb_wptr <= '0;
            frame_count <= '0;
            drop_count <= '0;
        end else if (beat) begin
            if (keep) begin
                wptr <= wptr + 1'b1;
                wcnt <= wcnt + 1'b1;
                state <= RECV;
            end else if (commit) begin
                wptr <= wptr + 1'b1;
                cptr <= wptr + 1'b1;
                wcnt <= '0;
                sb_wptr <= sb_wptr + 1'b1;
                state <= IDLE;
            end else begin
                wptr <= cptr;
                wcnt <= '0;
                state <= s.tlast ? IDLE : DROP;
            end
            if (commit && frame_count != 16'hFFFF)
                frame_count <= frame_count + 1'b1;
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (beat && admit && !full)
            mem[wptr[ADDR_WIDTH-1:0]] <= s.tdata;
        if (commit)
            sb_mem[sb_wptr[SB_ADDR_WIDTH-1:0]] <= wcnt + 1'b1;
        if (issue)
            rd_data <= mem[rptr[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ostate <= OIDLE;
            rem <= '0;
            rptr <= '0;
            sb_rptr <= '0;
            rd_v <= 1'b0;
            rd_last <= 1'b0;
            sk_valid <= 1'b0;
            sk_last <= 1'b0;
            sk_data <= '0;
            m.tvalid <= 1'b0;
            m.tlast <= 1'b0;
            m.tdata <= '0;
        end else begin
            rd_v <= issue;
            if (issue) begin
                rptr <= rptr + 1'b1;
                rd_last <= eff == LW'(1);
                rem <= eff - 1'b1;
                ostate <= (eff == LW'(1)) ? OIDLE : OSTREAM;
                if (ostate == OIDLE)
                    sb_rptr <= sb_rptr + 1'b1;
            end
            if (pop || !m.tvalid) begin
                m.tvalid <= sk_valid || rd_v;
                m.tdata <= sk_valid ? sk_data : rd_data;
                m.tlast <= sk_valid ? sk_last : rd_last;
                sk_valid <= sk_valid && rd_v;
                sk_data <= rd_data;
                sk_last <= rd_last;
            end else if (rd_v) begin
                sk_valid <= 1'b1;
                sk_data <= rd_data;
                sk_last <= rd_last;
            end
        end
    end
endmodule

// File: tb/tb_ingress_frame_filter.sv
// tb_ingress_frame_filter: directed and random frames on two configurations against a frame-level model
module tb_ingress_frame_filter;
    localparam int BIG = 1 << 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    always #5 clk = ~clk;

    ingress_frame_filter_if #(.DATA_WIDTH(16)) a_s();
    ingress_frame_filter_if #(.DATA_WIDTH(16)) a_m();
    ingress_frame_filter_if #(.DATA_WIDTH(16)) b_s();
    ingress_frame_filter_if #(.DATA_WIDTH(16)) b_m();
    logic [15:0] a_fc, a_dc, b_fc, b_dc;

    ingress_frame_filter #(.ADDR_WIDTH(4)) dut_a (
        .clk(clk), .reset(reset), .en(en), .s(a_s), .m(a_m),
        .frame_count(a_fc), .drop_count(a_dc)
    );
    ingress_frame_filter #(.MAX_FRAME_WORDS(8)) dut_b (
        .clk(clk), .reset(reset), .en(en), .s(b_s), .m(b_m),
        .frame_count(b_fc), .drop_count(b_dc)
    );

    logic [15:0] sd = '0;
    logic sv = 1'b0, sl = 1'b0, su = 1'b0, rdy = 1'b0;
    int sel = 0;
    int rdy_mode = 1;

    assign a_s.tdata = sd;
    assign a_s.tvalid = sv && sel == 0;
    assign a_s.tlast = sl;
    assign a_s.tuser = su;
    assign b_s.tdata = sd;
    assign b_s.tvalid = sv && sel == 1;
    assign b_s.tlast = sl;
    assign b_s.tuser = su;
    assign a_m.tready = rdy;
    assign b_m.tready = rdy;

    int checks = 0;
    int failures = 0;
    logic [16:0] exp_a[$];
    logic [16:0] exp_b[$];
    int exp_fc[2];
    int exp_dc[2];
    logic stall[2];
    logic [16:0] prev[2];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // frame-level rules: en at first beat, fits in free space, within max length, no error flag
    task automatic model_frame(int d, int len, logic [15:0] base, logic user, logic en0, int space);
        int maxw;
        logic [15:0] w;
        maxw = d ? 8 : 759;
        if (!en0)
            return;
        if (len > space || len > maxw || user) begin
            exp_dc[d]++;
            return;
        end
        exp_fc[d]++;
        for (int i = 0; i < len; i++) begin
            w = base + 16'(i);
            if (d == 0) exp_a.push_back({i == len - 1, w});
            else exp_b.push_back({i == len - 1, w});
        end
    endtask

    task automatic frame(int d, int len, logic [15:0] base, logic user, logic en0, logic en1, int space, int gap);
        model_frame(d, len, base, user, en0, space);
        sel = d;
        for (int i = 0; i < len; i++) begin
            en = (i == 0) ? en0 : en1;
            sd = base + 16'(i);
            sv = 1'b1;
            sl = i == len - 1;
            su = user && i == len - 1;
            @(posedge clk);
            #1;
        end
        sv = 1'b0;
        sl = 1'b0;
        su = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mon(int d, logic v, logic r, logic l, logic [15:0] dat);
        logic [16:0] w;
        w = {l, dat};
        if (stall[d])
            check(d ? "hold_b" : "hold_a", {14'b0, v, w}, {14'b0, 1'b1, prev[d]});
        if (v && r) begin
            if (d == 0) begin
                if (exp_a.size() == 0) check("extra_a", 32'(w), 32'hDEADBEEF);
                else check("data_a", 32'(w), 32'(exp_a.pop_front()));
            end else begin
                if (exp_b.size() == 0) check("extra_b", 32'(w), 32'hDEADBEEF);
                else check("data_b", 32'(w), 32'(exp_b.pop_front()));
            end
        end
        stall[d] = v && !r;
        prev[d] = w;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            stall[0] = 1'b0;
            stall[1] = 1'b0;
        end else begin
            mon(0, a_m.tvalid, a_m.tready, a_m.tlast, a_m.tdata);
            mon(1, b_m.tvalid, b_m.tready, b_m.tlast, b_m.tdata);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        rdy = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end

    task automatic clear_model();
        exp_a.delete();
        exp_b.delete();
        exp_fc[0] = 0;
        exp_fc[1] = 0;
        exp_dc[0] = 0;
        exp_dc[1] = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_tready_a", 32'(a_s.tready), 0);
        check("rst_tvalid_a", 32'(a_m.tvalid), 0);
        check("rst_tlast_a", 32'(a_m.tlast), 0);
        check("rst_tdata_a", 32'(a_m.tdata), 0);
        check("rst_fc_a", 32'(a_fc), 0);
        check("rst_dc_a", 32'(a_dc), 0);
        check("rst_tvalid_b", 32'(b_m.tvalid), 0);
        check("rst_fc_b", 32'(b_fc), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        clear_model();
        reset = 1'b0;
        #1;
        check("tready_a", 32'(a_s.tready), 1);
        check("tready_b", 32'(b_s.tready), 1);
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check("drain_a", exp_a.size(), 0);
        check("drain_b", exp_b.size(), 0);
    endtask

    task automatic check_counts(string tag);
        check({tag, "_fc_a"}, 32'(a_fc), exp_fc[0]);
        check({tag, "_dc_a"}, 32'(a_dc), exp_dc[0]);
        check({tag, "_fc_b"}, 32'(b_fc), exp_fc[1]);
        check({tag, "_dc_b"}, 32'(b_dc), exp_dc[1]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, len;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        // three back-to-back 4-word frames, then a lone word to measure latency
        rdy_mode = 1;
        frame(0, 4, 16'h0001, 0, 1, 1, BIG, 0);
        frame(0, 4, 16'h0005, 0, 1, 1, BIG, 0);
        frame(0, 4, 16'h0009, 0, 1, 1, BIG, 0);
        drain(100);
        check_counts("three");
        frame(0, 1, 16'h000D, 0, 1, 1, BIG, 0);
        n = 0;
        while (!a_m.tvalid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency_le3", 32'(n <= 3), 1);
        drain(50);
        do_reset();
        frame(0, 5, 16'h0600, 1, 1, 1, BIG, 0);
        frame(0, 2, 16'h0610, 0, 1, 1, BIG, 0);
        drain(100);
        check_counts("err");
        do_reset();
        frame(1, 10, 16'h0500, 0, 1, 1, BIG, 0);
        frame(1, 3, 16'h0510, 0, 1, 1, BIG, 0);
        drain(100);
        check_counts("max");
        // full buffer with egress stalled
        do_reset();
        rdy_mode = 0;
        frame(0, 20, 16'h0400, 0, 1, 1, 16, 0);
        frame(0, 6, 16'h0420, 0, 1, 1, 16, 4);
        check_counts("full");
        check("full_stall_valid", 32'(a_m.tvalid), 1);
        check("full_stall_data", 32'(a_m.tdata), 32'h0420);
        rdy_mode = 1;
        drain(100);
        do_reset();
        frame(0, 4, 16'h0300, 0, 0, 1, BIG, 2);
        check_counts("en_off");
        frame(0, 4, 16'h0310, 0, 1, 0, BIG, 0);
        drain(100);
        check_counts("en_mid");
        // reset during word 3 with a committed frame still stored
        do_reset();
        rdy_mode = 0;
        frame(0, 3, 16'h0100, 0, 1, 1, BIG, 3);
        sel = 0;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sd = 16'h0200 + 16'(i);
            sv = 1'b1;
            if (i < 2) begin
                @(posedge clk);
                #1;
            end
        end
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs();
        sv = 1'b0;
        @(posedge clk);
        #1;
        clear_model();
        reset = 1'b0;
        rdy_mode = 2;
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(1, 4);
            frame(0, len, 16'($urandom), 0, 1, 1, 16, 0);
            drain(200);
        end
        check_counts("post_rst");
        // random traffic on the large-buffer instance
        for (int k = 0; k < 150; k++) begin
            len = $urandom_range(1, 10);
            frame(1, len, 16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0,
                  1'($urandom_range(0, 1)), BIG, $urandom_range(0, 2));
        end
        drain(6000);
        check_counts("rand");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ingress_frame_filter.md
INGRESS_FRAME_FILTER -- requirements
Module: ingress_frame_filter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, the stream word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 11, the frame-buffer depth of 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter SB_ADDR_WIDTH, default 9, the sideband (length) FIFO depth of 2**SB_ADDR_WIDTH entries.
REQ-004 The block SHALL have parameter MAX_FRAME_WORDS, default 759, the longest accepted frame in words.
REQ-005 The block SHALL have parameter DROP_ON_ERROR, default 1; when 1, frames ending with s_tuser=1 are dropped.
REQ-006 The block SHALL have these ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  frame-admission enable.
- s_tdata  in  DATA_WIDTH  ingress word.
- s_tvalid  in  1  ingress valid.
- s_tlast  in  1  last ingress word of the frame.
- s_tuser  in  1  error flag, sampled with s_tlast.
- s_tready  out  1  ingress ready.
- m_tdata  out  DATA_WIDTH  egress word.
- m_tvalid  out  1  egress valid.
- m_tlast  out  1  last egress word.
- m_tready  in  1  egress ready.
- frame_count  out  16  committed frames.
- drop_count  out  16  dropped frames.

Function
REQ-007 s_tready SHALL be 1 whenever reset is low; the block never back-pressures ingress and drops frames instead.
REQ-008 The input FSM SHALL have states IDLE, RECV and DROP; a beat is a cycle with s_tvalid=1 and s_tready=1.
REQ-009 In IDLE, a beat SHALL be written and the FSM SHALL go to RECV only if en=1, the frame buffer is not full and the sideband FIFO is not full.
- If en=1 and either buffer is full, the beat SHALL start a drop: enter DROP, or stay in IDLE if s_tlast=1.
- If en=0, the beat SHALL be discarded as in the previous bullet, and drop_count SHALL NOT be incremented.
REQ-010 en SHALL be sampled only at the first beat of a frame; deasserting en mid-frame SHALL NOT affect that frame.
REQ-011 In RECV, each beat SHALL be written at wptr, and wptr and the word counter SHALL increment by one.
REQ-012 A frame SHALL be aborted if, in RECV, a beat arrives while the buffer is full, or the word counter reaches MAX_FRAME_WORDS without s_tlast.
- On abort, wptr SHALL rewind to the frame start pointer and drop_count SHALL increment.
- The FSM SHALL then enter DROP, or IDLE if the aborting beat carries s_tlast.
REQ-013 On an s_tlast beat in RECV with s_tuser=1 and DROP_ON_ERROR=1, the frame SHALL be discarded by rewinding wptr and incrementing drop_count.
REQ-014 On any other s_tlast beat, the frame SHALL be committed in the same cycle:
- push its length in words into the sideband FIFO;
- set commit pointer := wptr+1;
- increment frame_count;
- go to IDLE.
REQ-015 A one-word frame (first beat carries s_tlast) SHALL be committed from IDLE directly.
REQ-016 In DROP, beats SHALL be discarded until the s_tlast beat, after which the FSM SHALL return to IDLE.
REQ-017 Pointers SHALL be ADDR_WIDTH+1 bits and wrap naturally.
- full: MSBs differ and the lower bits are equal.
- Egress SHALL read only up to the commit pointer, so uncommitted words are never visible.
REQ-018 The egress FSM SHALL have states OIDLE and OSTREAM.
- It SHALL leave OIDLE when the sideband FIFO is non-empty, popping one length.
- It SHALL stream exactly that many words, with m_tlast=1 on the last word.
- It SHALL return to OIDLE, or start the next frame back-to-back.
REQ-019 The buffer read SHALL be synchronous with a prefetch/skid register.
- m_tvalid SHALL assert at most 3 cycles after commit when egress is idle.
- Throughput SHALL be one word per cycle while m_tready=1.
REQ-020 While m_tvalid=1 and m_tready=0, m_tdata and m_tlast SHALL hold stable.
REQ-021 Simultaneous commit and egress pop, and simultaneous write and read of the buffer, SHALL both complete in the same cycle without loss.
REQ-022 frame_count and drop_count SHALL saturate at 16'hFFFF.

Reset
REQ-023 While reset=1, all of the following SHALL hold:
- s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0;
- frame_count=0, drop_count=0;
- all pointers and counters 0;
- FSMs in IDLE/OIDLE.
REQ-024 Reset asserted mid-frame SHALL discard all stored and partial frames; no output is produced for them after release.

Verification
REQ-025 Bench SHALL cover: three 4-word frames (0x0001..0x000C), m_tready=1 -> same 12 words out in order, m_tlast on words 4/8/12, frame_count=3.
REQ-026 Bench SHALL cover: 5-word frame ending with s_tuser=1, DROP_ON_ERROR=1, then 2-word frame -> only the 2-word frame emitted, drop_count=1, frame_count=1.
REQ-027 Bench SHALL cover: MAX_FRAME_WORDS=8, a 10-word frame then a 3-word frame -> only the 3-word frame emitted, drop_count=1.
REQ-028 Bench SHALL cover: ADDR_WIDTH=4, m_tready=0, 20-word frame then a 6-word frame -> first aborted at the full buffer, second stored; after m_tready=1 only the 6 words come out.
REQ-029 Bench SHALL cover: en=0 at the first beat of a 4-word frame, en=1 mid-frame -> frame discarded, counters unchanged; en=1 at the first beat then en=0 mid-frame -> frame committed.
REQ-030 Bench SHALL cover: reset pulsed during word 3 of a frame, m_tready toggled randomly afterwards -> outputs at reset values; subsequent frames intact, data stable on stalls.
